// File: rtl/instr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : instr_reg_arbiter
//  Description : Two-requester round-robin arbiter that writes instructions
//                into an external DEPTH-slot instruction register and serves
//                them to a single consumer in write order.
//
//  Ports
//    clk, reset                 clock, synchronous active-high reset
//    enable                     1 = accept requests, 0 = idle
//    drain_req                  pulse: stop accepting writes, empty register
//    req_valid[1:0]             requester valid (bit 0 = A, bit 1 = B)
//    req_opcode_a/_b            requester opcode
//    req_operand_a_a/_b         operand A of requester A / B
//    req_operand_b_a/_b         operand B of requester A / B
//    req_ready[1:0]             per-requester grant
//    load_en                    register write strobe
//    opcode, operand_a/b        write data of the granted requester
//    write_pointer/read_pointer register addresses
//    instruction_word           combinational read data from the register
//    rd_valid / rd_ready        consumer handshake
//    rd_instruction             instruction_word passed through
//    count                      number of unread slots
//    drain_done                 one-cycle pulse when a drain completes
//
//  Revision    : 1.0  initial release
// ============================================================================
module instr_reg_arbiter #(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int OPCODE_W  = 4,
    parameter int OPERAND_W = 8,
    parameter int INSTR_W   = OPCODE_W + 2 * OPERAND_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 drain_req,
    input  logic [1:0]           req_valid,
    input  logic [OPCODE_W-1:0]  req_opcode_a,
    input  logic [OPCODE_W-1:0]  req_opcode_b,
    input  logic [OPERAND_W-1:0] req_operand_a_a,
    input  logic [OPERAND_W-1:0] req_operand_a_b,
    input  logic [OPERAND_W-1:0] req_operand_b_a,
    input  logic [OPERAND_W-1:0] req_operand_b_b,
    output logic [1:0]           req_ready,
    output logic                 load_en,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic [ADDR_W-1:0]    write_pointer,
    output logic [ADDR_W-1:0]    read_pointer,
    input  logic [INSTR_W-1:0]   instruction_word,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [INSTR_W-1:0]   rd_instruction,
    output logic [ADDR_W:0]      count,
    output logic                 drain_done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam int              c_DEPTH_M1 = DEPTH - 1;
    localparam logic [ADDR_W:0]   c_FULL   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] c_LAST   = c_DEPTH_M1[ADDR_W-1:0];

    logic [1:0]           r_state;
    logic [ADDR_W-1:0]    r_wp;
    logic [ADDR_W-1:0]    r_rp;
    logic [ADDR_W:0]      r_count;
    logic                 r_prio_b;   // 1: B is favoured on a tie
    logic [OPCODE_W-1:0]  r_opcode;
    logic [OPERAND_W-1:0] r_operand_a;
    logic [OPERAND_W-1:0] r_operand_b;

    logic       w_full;
    logic       w_grant_ok;
    logic [1:0] w_grant;
    logic       w_load;
    logic       w_read;

    // Fullness comes from the registered count only, so a read in the same
    // cycle never frees a slot for a same-cycle write.
    assign w_full     = (r_count == c_FULL);
    assign w_grant_ok = (r_state == c_RUN) && !w_full && !reset;

    always_comb begin
        w_grant = 2'b00;
        if (w_grant_ok) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_prio_b ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_load   = |w_grant;
    assign w_read   = rd_valid && rd_ready;

    assign req_ready      = w_grant;
    assign load_en        = w_load;
    assign rd_valid       = (r_count != '0);
    assign rd_instruction = instruction_word;
    assign write_pointer  = r_wp;
    assign read_pointer   = r_rp;
    assign count          = r_count;
    assign drain_done     = (r_state == c_DRAIN) && (r_count == '0) && !reset;

    // Write data follows the granted requester; otherwise the last granted
    // values are presented.
    always_comb begin
        opcode    = r_opcode;
        operand_a = r_operand_a;
        operand_b = r_operand_b;
        if (w_grant[0]) begin
            opcode    = req_opcode_a;
            operand_a = req_operand_a_a;
            operand_b = req_operand_b_a;
        end else if (w_grant[1]) begin
            opcode    = req_opcode_b;
            operand_a = req_operand_a_b;
            operand_b = req_operand_b_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_prio_b    <= 1'b0;
            r_opcode    <= '0;
            r_operand_a <= '0;
            r_operand_b <= '0;
        end else begin
            case (r_state)
                c_IDLE:  if (enable) r_state <= c_RUN;
                c_RUN: begin
                    if (drain_req)    r_state <= c_DRAIN;
                    else if (!enable) r_state <= c_IDLE;
                end
                c_DRAIN: if (r_count == '0) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase

            if (w_load) begin
                r_wp        <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
                // Favour whichever requester was not just served.
                r_prio_b    <= w_grant[0];
                r_opcode    <= opcode;
                r_operand_a <= operand_a;
                r_operand_b <= operand_b;
            end

            if (w_read) begin
                r_rp <= (r_rp == c_LAST) ? '0 : r_rp + 1'b1;
            end

            case ({w_load, w_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_reg_arbiter
//  Description : Self-checking bench for instr_reg_arbiter. A queue-based
//                model of the instruction register predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_reg_arbiter;

    localparam int DEPTH     = 32;
    localparam int ADDR_W    = 5;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 8;
    localparam int INSTR_W   = OPCODE_W + 2 * OPERAND_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 drain_req;
    logic [1:0]           req_valid;
    logic [OPCODE_W-1:0]  req_opcode_a, req_opcode_b;
    logic [OPERAND_W-1:0] req_operand_a_a, req_operand_a_b;
    logic [OPERAND_W-1:0] req_operand_b_a, req_operand_b_b;
    logic [1:0]           req_ready;
    logic                 load_en;
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand_a, operand_b;
    logic [ADDR_W-1:0]    write_pointer, read_pointer;
    logic [INSTR_W-1:0]   instruction_word;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [INSTR_W-1:0]   rd_instruction;
    logic [ADDR_W:0]      count;
    logic                 drain_done;

    instr_reg_arbiter #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .drain_req(drain_req),
        .req_valid(req_valid),
        .req_opcode_a(req_opcode_a), .req_opcode_b(req_opcode_b),
        .req_operand_a_a(req_operand_a_a), .req_operand_a_b(req_operand_a_b),
        .req_operand_b_a(req_operand_b_a), .req_operand_b_b(req_operand_b_b),
        .req_ready(req_ready), .load_en(load_en),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_instruction(rd_instruction),
        .count(count), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    // The instruction register storage that the arbiter addresses.
    logic [INSTR_W-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
    assign instruction_word = mem[read_pointer];

    // Reference model: 0 = idle, 1 = run, 2 = drain; contents kept as a queue.
    int                   m_state;
    logic [INSTR_W-1:0]   m_q[$];
    int                   m_wp, m_rp;
    int                   m_last;          // index of requester granted last
    logic [OPCODE_W-1:0]  m_op;
    logic [OPERAND_W-1:0] m_a, m_b;

    int n_cmp, n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_wp    = 0;
        m_rp    = 0;
        m_last  = 1;
        m_op    = '0;
        m_a     = '0;
        m_b     = '0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cycle(input logic r, input logic en, input logic dr,
                         input logic [1:0] v, input logic rr);
        int         g;
        int         occ;
        logic [1:0] exp_ready;
        logic       rd;
        reset           = r;
        enable          = en;
        drain_req       = dr;
        req_valid       = v;
        rd_ready        = rr;
        req_opcode_a    = 4'($urandom);
        req_opcode_b    = 4'($urandom);
        req_operand_a_a = 8'($urandom);
        req_operand_a_b = 8'($urandom);
        req_operand_b_a = 8'($urandom);
        req_operand_b_b = 8'($urandom);
        @(negedge clk);
        occ = m_q.size();
        g   = -1;
        if (!r && m_state == 1 && occ < DEPTH) begin
            if (v == 2'b11)   g = (m_last == 0) ? 1 : 0;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        exp_ready = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        if (g == 0) begin
            m_op = req_opcode_a; m_a = req_operand_a_a; m_b = req_operand_b_a;
        end else if (g == 1) begin
            m_op = req_opcode_b; m_a = req_operand_a_b; m_b = req_operand_b_b;
        end
        chk("req_ready",     64'(req_ready),     64'(exp_ready));
        chk("load_en",       64'(load_en),       64'(g >= 0));
        chk("opcode",        64'(opcode),        64'(m_op));
        chk("operand_a",     64'(operand_a),     64'(m_a));
        chk("operand_b",     64'(operand_b),     64'(m_b));
        chk("write_pointer", 64'(write_pointer), 64'(m_wp));
        chk("read_pointer",  64'(read_pointer),  64'(m_rp));
        chk("count",         64'(count),         64'(occ));
        chk("rd_valid",      64'(rd_valid),      64'(occ != 0));
        chk("drain_done",    64'(drain_done),    64'(!r && m_state == 2 && occ == 0));
        if (occ != 0) chk("rd_instruction", 64'(rd_instruction), 64'(m_q[0]));

        rd = (occ != 0) && rr;
        if (r) begin
            model_reset();
        end else begin
            if (rd) begin
                void'(m_q.pop_front());
                m_rp = (m_rp + 1) % DEPTH;
            end
            if (g >= 0) begin
                m_q.push_back({m_op, m_a, m_b});
                m_wp   = (m_wp + 1) % DEPTH;
                m_last = g;
            end
            case (m_state)
                0:       if (en) m_state = 1;
                1:       if (dr) m_state = 2; else if (!en) m_state = 0;
                default: if (occ == 0) m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p_rd;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset = 1'b1; enable = 1'b0; drain_req = 1'b0; req_valid = 2'b00; rd_ready = 1'b0;
        req_opcode_a = '0; req_opcode_b = '0;
        req_operand_a_a = '0; req_operand_a_b = '0; req_operand_b_a = '0; req_operand_b_b = '0;
        @(posedge clk);
        #1;

        // Single write from A, then read it back.
        cycle(1, 0, 0, 2'b00, 0);
        cycle(0, 1, 0, 2'b01, 0);
        cycle(0, 1, 0, 2'b01, 0);
        cycle(0, 1, 0, 2'b00, 0);
        cycle(0, 1, 0, 2'b00, 1);

        // Both valid: alternating grants.
        cycle(1, 0, 0, 2'b00, 0);
        cycle(0, 1, 0, 2'b11, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 2'b11, 0);
        // Only B valid while B is not favoured, then tie again.
        cycle(0, 1, 0, 2'b10, 0);
        cycle(0, 1, 0, 2'b10, 0);
        cycle(0, 1, 0, 2'b11, 0);

        // Fill to full, hold, one read, refill.
        cycle(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 40; i++) cycle(0, 1, 0, 2'b11, 0);
        cycle(0, 1, 0, 2'b11, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b11, 0);

        // Streaming write and read across pointer wrap.
        cycle(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 70; i++) cycle(0, 1, 0, 2'($urandom_range(1, 3)), 1);

        // Drain with three entries, drain_req repeated inside DRAIN.
        cycle(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 2'b01, 0);
        cycle(0, 1, 1, 2'b11, 0);
        cycle(0, 1, 1, 2'b11, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 2'b11, 1);

        // Drain entered empty; drain_req in IDLE ignored.
        cycle(0, 1, 1, 2'b00, 1);
        cycle(0, 1, 0, 2'b00, 1);
        cycle(0, 0, 0, 2'b11, 1);
        cycle(0, 0, 0, 2'b11, 1);
        cycle(0, 0, 1, 2'b11, 1);
        cycle(0, 0, 0, 2'b11, 1);

        // Reset in the middle of traffic with ten entries held.
        cycle(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, 2'b11, 0);
        cycle(1, 1, 0, 2'b11, 1);
        cycle(0, 1, 0, 2'b11, 1);
        cycle(0, 1, 0, 2'b11, 1);

        // Randomized traffic with phased read pressure.
        p_rd = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p_rd = (i / 200 % 3 == 0) ? 12 : (i / 200 % 3 == 1) ? 88 : 50;
            cycle(($urandom_range(0, 255) == 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 39) == 0),
                  2'($urandom),
                  ($urandom_range(0, 99) < p_rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_reg_arbiter.md
INSTR_REG_ARBITER -- requirements
Module: instr_reg_arbiter

Interface
REQ-001 Parameter DEPTH, default 32, number of instruction register slots.
REQ-002 Parameter ADDR_W, default 5, pointer width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high: arbiter accepts requests; low: arbiter idles.
REQ-006 drain_req  input  1  pulse: stop accepting writes and empty the register.
REQ-007 req_valid[1:0]  input  2  per-requester valid (index 0 = A, 1 = B).
REQ-008 req_opcode_a/_b  input  opcode_t  per-requester opcode.
REQ-009 req_operand_a_a/_b, req_operand_b_a/_b  input  operand_t  per-requester operands.
REQ-010 req_ready[1:0]  output  2  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-011 load_en  output  1  write strobe to the instruction register.
REQ-012 opcode, operand_a, operand_b  output  opcode_t/operand_t  muxed write data for the granted requester.
REQ-013 write_pointer, read_pointer  output  ADDR_W  register addresses.
REQ-014 instruction_word  input  instruction_t  combinational read data from the register.
REQ-015 rd_valid  output  1  high when the register holds unread data.
REQ-016 rd_ready  input  1  consumer accept.
REQ-017 rd_instruction  output  instruction_t  equals instruction_word, unmodified.
REQ-018 count  output  ADDR_W+1  number of unread slots.
REQ-019 drain_done  output  1  one-cycle pulse when a drain completes.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DRAIN with these transitions:
- IDLE->RUN when enable=1.
- RUN->IDLE when enable=0.
- RUN->DRAIN on drain_req=1.
- DRAIN->IDLE when count=0, with drain_done=1 in that cycle.
REQ-021 req_ready SHALL be 0 in IDLE and DRAIN, and 0 whenever count=DEPTH (full).
REQ-022 In RUN and not full, the arbiter SHALL grant exactly one valid requester per cycle, using round-robin priority that favours the requester not granted last.
REQ-023 If only one requester is valid, it SHALL be granted regardless of priority.
REQ-024 The priority pointer SHALL toggle only on an accepted transfer.
REQ-025 load_en, opcode and operands SHALL be combinational from the granted requester.
- load_en=1 exactly in the cycles a transfer occurs.
- Data outputs SHALL be held at the last granted values otherwise.
REQ-026 write_pointer SHALL increment by 1 after each write, wrapping from DEPTH-1 to 0.
REQ-027 rd_valid SHALL equal (count!=0) in every state, including IDLE and DRAIN.
REQ-028 read_pointer SHALL increment by 1, wrapping, on each cycle with rd_valid=1 and rd_ready=1.
REQ-029 count SHALL update as follows:
- +1 on write only.
- -1 on read only.
- Unchanged on a simultaneous write and read.
- Never exceed DEPTH or underflow.
REQ-030 When full, a simultaneous read SHALL NOT enable a same-cycle write; ready is derived from the registered count.
REQ-031 Read latency SHALL be zero cycles; a write becomes readable the cycle after load_en.
REQ-032 A drain_req arriving while in IDLE SHALL be ignored.
REQ-033 A drain_req arriving while already in DRAIN SHALL be ignored.
REQ-034 In DRAIN with count=0 already on entry, drain_done SHALL pulse the next cycle.

Reset
REQ-035 In any cycle with reset=1, the block SHALL enter IDLE and clear write_pointer, read_pointer, count, the priority pointer (favouring A) and drain_done.
REQ-036 reset SHALL override all concurrent requests and reads mid-operation.
REQ-037 load_en SHALL be 0 during reset and in the cycle reset deasserts.

Verification
REQ-038 Reset, enable=1, A valid with ADD, 5, 3 -> load_en=1 and write_pointer=0; next cycle rd_valid=1, count=1, and read_pointer=0 sees the instruction.
REQ-039 A and B both valid for 4 cycles from reset -> grants in the order A, B, A, B; write_pointer goes 0 to 4; count=4.
REQ-040 32 writes with rd_ready=0 -> count=32 and req_ready=00; then one read -> count=31 and req_ready returns next cycle.
REQ-041 Continuous write and read across 40 transfers -> both pointers wrap 31->0; count stays constant.
REQ-042 drain_req with count=3 and rd_ready=1 -> no grants; count goes 3, 2, 1, 0; drain_done pulses once; state becomes IDLE.
REQ-043 reset asserted with count=10 mid-transfer -> next cycle count=0, both pointers=0, rd_valid=0, load_en=0.
